// File: rtl/imem_loader.sv
// imem_loader -- streams a program into instruction memory over a byte channel.
//
// Stream: 16-bit little-endian word count LEN, then 4*LEN bytes, each word
// little-endian (first byte lands in wdata[7:0]). LEN==0 completes at once;
// LEN>DEPTH is rejected and parks in ERR until the next start.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             single-cycle pulse, begins a load from IDLE/DONE/ERR
//   rx_data/rx_valid  byte stream in; rx_ready accepts (beat = valid & ready)
//   we/waddr/wdata    one write strobe per assembled word, waddr = word index
//   cpu_hold          holds the core whenever the program is not valid
//   busy/done/err     load in progress / program valid / load rejected
module imem_loader #(
    parameter int DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;

    // Status outputs are registered alongside the state: every transition
    // loads the flag set belonging to the state being entered.
    // Order: {rx_ready, busy, done, err, cpu_hold}
    function automatic logic [4:0] flags(state_t s);
        case (s)
            HDR0, HDR1, DATA: flags = 5'b11001;
            WRITE:            flags = 5'b01001;
            DONE:             flags = 5'b00100;
            ERR:              flags = 5'b00011;
            default:          flags = 5'b00001;
        endcase
    endfunction

    state_t      state;
    logic [4:0]  flag_q;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_q;
    logic        beat;

    assign {rx_ready, busy, done, err, cpu_hold} = flag_q;
    assign beat = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flag_q   <= flags(IDLE);
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR0;
                        flag_q   <= flags(HDR0);
                        len      <= '0;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                HDR0: begin
                    if (beat) begin
                        len[7:0] <= rx_data;
                        state    <= HDR1;
                        flag_q   <= flags(HDR1);
                    end
                end
                HDR1: begin
                    if (beat) begin
                        len[15:8] <= rx_data;
                        word_cnt  <= '0;
                        byte_cnt  <= '0;
                        if ({rx_data, len[7:0]} == 16'd0) begin
                            state  <= DONE;
                            flag_q <= flags(DONE);
                        end else if (32'({rx_data, len[7:0]}) > 32'(DEPTH)) begin
                            state  <= ERR;
                            flag_q <= flags(ERR);
                        end else begin
                            state  <= DATA;
                            flag_q <= flags(DATA);
                        end
                    end
                end
                DATA: begin
                    if (beat) begin
                        // Shift in from the top so the first byte ends at [7:0].
                        asm_q    <= {rx_data, asm_q[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Strobe is launched here so it is high exactly
                            // during the WRITE cycle.
                            we     <= 1'b1;
                            waddr  <= {16'd0, word_cnt};
                            wdata  <= {rx_data, asm_q[31:8]};
                            state  <= WRITE;
                            flag_q <= flags(WRITE);
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 16'd1;
                    byte_cnt <= '0;
                    if (16'(word_cnt + 16'd1) == len) begin
                        state  <= DONE;
                        flag_q <= flags(DONE);
                    end else begin
                        state  <= DATA;
                        flag_q <= flags(DATA);
                    end
                end
                default: begin
                    state  <= IDLE;
                    flag_q <= flags(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, we, cpu_hold, busy, done, err;
    logic [31:0] waddr, wdata;

    imem_loader #(.DEPTH(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Write monitor, sampled on the falling edge (mid-cycle).
    int          cyc = 0;
    int          last_beat = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_lat[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (we) begin
            wr_addr.push_back(waddr);
            wr_data.push_back(wdata);
            wr_lat.push_back(cyc - last_beat);
        end
        if (rx_valid && rx_ready) last_beat = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_lat.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        if (gap > 0) step(gap);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            step(1);
            n++;
        end
        if (!rx_ready) chk("send_timeout", {31'd0, rx_ready}, 32'd1);
        step(1);
        rx_valid = 1'b0;
        rx_data  = 8'hxx;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 20) begin
            step(1);
            n++;
        end
        chk("wait_end", {31'd0, done | err}, 32'd1);
    endtask

    task automatic check_two_word(input string tag);
        chk({tag, "_nwr"}, wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk({tag, "_a0"}, wr_addr[0], 32'd0);
            chk({tag, "_d0"}, wr_data[0], 32'h0000_0013);
            chk({tag, "_l0"}, wr_lat[0], 1);
            chk({tag, "_a1"}, wr_addr[1], 32'd1);
            chk({tag, "_d1"}, wr_data[1], 32'h4017_D793);
            chk({tag, "_l1"}, wr_lat[1], 1);
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] two_word[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                 8'h93, 8'hD7, 8'h17, 8'h40};

    initial begin
        // Reset
        step(2);
        chk("rst_ready", {31'd0, rx_ready}, 0);
        chk("rst_we",    {31'd0, we}, 0);
        chk("rst_busy",  {31'd0, busy}, 0);
        chk("rst_done",  {31'd0, done}, 0);
        chk("rst_err",   {31'd0, err}, 0);
        chk("rst_hold",  {31'd0, cpu_hold}, 1);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        rst = 1'b0;
        step(2);
        chk("idle_ready", {31'd0, rx_ready}, 0);

        // Two-word load
        clear_log();
        pulse_start();
        chk("hdr_busy",  {31'd0, busy}, 1);
        chk("hdr_ready", {31'd0, rx_ready}, 1);
        for (int i = 0; i < 10; i++) send(two_word[i], 0);
        wait_end();
        step(2);
        check_two_word("load");
        chk("hold_waddr", waddr, 32'd1);
        chk("hold_wdata", wdata, 32'h4017_D793);

        // Empty load from DONE
        clear_log();
        pulse_start();
        chk("restart_done", {31'd0, done}, 0);
        chk("restart_hold", {31'd0, cpu_hold}, 1);
        send(8'h00, 0);
        send(8'h00, 0);
        wait_end();
        step(2);
        chk("empty_done", {31'd0, done}, 1);
        chk("empty_nwr",  wr_addr.size(), 0);

        // Length error, then recovery
        clear_log();
        pulse_start();
        send(8'h0B, 0);
        send(8'h00, 0);
        wait_end();
        step(2);
        chk("len_err",  {31'd0, err}, 1);
        chk("len_hold", {31'd0, cpu_hold}, 1);
        chk("len_done", {31'd0, done}, 0);
        chk("len_nwr",  wr_addr.size(), 0);
        pulse_start();
        chk("err_clr", {31'd0, err}, 0);
        send(8'h01, 0); send(8'h00, 0);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
        wait_end();
        step(1);
        chk("rec_nwr", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            chk("rec_a", wr_addr[0], 0);
            chk("rec_d", wr_data[0], 32'hDEAD_BEEF);
        end
        chk("rec_done", {31'd0, done}, 1);

        // LEN == DEPTH: largest accepted load
        clear_log();
        pulse_start();
        send(8'h0A, 0);
        send(8'h00, 0);
        for (int w = 0; w < 10; w++) begin
            send(8'(w), 0); send(8'h00, 0); send(8'h00, 0); send(8'h10, 0);
        end
        wait_end();
        step(1);
        chk("max_nwr", wr_addr.size(), 10);
        if (wr_addr.size() == 10) begin
            chk("max_last_a", wr_addr[9], 32'd9);
            chk("max_last_d", wr_data[9], 32'h1000_0009);
            chk("max_first_d", wr_data[0], 32'h1000_0000);
        end
        chk("max_done", {31'd0, done}, 1);

        // Back-pressure with random gaps and a stray start mid-load
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send(two_word[i], $urandom_range(0, 5));
            if (i == 4) pulse_start();
        end
        wait_end();
        step(2);
        check_two_word("bp");

        // Reset in the middle of DATA
        clear_log();
        pulse_start();
        send(8'h02, 0); send(8'h00, 0); send(8'h13, 0); send(8'h00, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        chk("mid_busy",  {31'd0, busy}, 0);
        chk("mid_hold",  {31'd0, cpu_hold}, 1);
        chk("mid_ready", {31'd0, rx_ready}, 0);
        chk("mid_done",  {31'd0, done}, 0);
        chk("mid_nwr",   wr_addr.size(), 0);
        pulse_start();
        for (int i = 0; i < 10; i++) send(two_word[i], 0);
        wait_end();
        step(2);
        check_two_word("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
